ahblite_busmatrix_arbiter_rr: RTL and testbench
===============================================

AHBLITE_BUSMATRIX_ARBITER_RR -- requirements
Module: ahblite_busmatrix_arbiter_rr

Interface
REQ-001 SHALL have parameter PORT_DEFAULT, default 2'b00, meaning the port code granted out of reset; 2'b00 means no port.
REQ-002 SHALL have port HCLK, input, 1 bit: the single clock, rising-edge.
REQ-003 SHALL have port HRESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port REQ_ICODE, input, 1 bit: ICODE master requests this slave.
REQ-005 SHALL have port REQ_DCODE, input, 1 bit: DCODE master requests this slave.
REQ-006 SHALL have port REQ_SYS, input, 1 bit: SYS master requests this slave.
REQ-007 SHALL have port HREADY_Outputstage, input, 1 bit: slave-side HREADY of the controlled output stage.
REQ-008 SHALL have port HSEL_Outputstage, input, 1 bit: slave-side HSEL.
REQ-009 SHALL have port HTRANS_Outputstage, input, 2 bits: slave-side HTRANS.
REQ-010 SHALL have port HBURST_Outputstage, input, 3 bits: slave-side HBURST.
REQ-011 SHALL have port PORT_SEL_ARBITER, output, 2 bits: granted port; 01 = ICODE, 10 = DCODE, 11 = SYS.
REQ-012 SHALL have port PORT_NOSEL_ARBITER, output, 1 bit: high when no port is granted.

Function
REQ-013 PORT_SEL_ARBITER and PORT_NOSEL_ARBITER SHALL be registered and SHALL change only on a rising HCLK edge where HREADY_Outputstage=1.
REQ-014 The FSM SHALL have three states:
- IDLE: no grant.
- GRANT: single transfer or first beat.
- BURST: locked.
REQ-015 IDLE->GRANT SHALL occur on any request; the grant SHALL be visible one cycle after the request is sampled with HREADY high.
REQ-016 GRANT->BURST SHALL occur when HSEL=1, HTRANS=NONSEQ and HBURST is not SINGLE.
REQ-017 GRANT->GRANT SHALL re-arbitrate each ready cycle; GRANT->IDLE SHALL occur when no request is pending and HTRANS is IDLE.
REQ-018 In BURST, re-arbitration SHALL be blocked and the current grant held.
REQ-019 Fixed-length bursts (INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16) SHALL load a beat counter with 3, 7 or 15 on the accepted NONSEQ.
REQ-020 The beat counter SHALL decrement on each accepted SEQ beat; BURST SHALL exit after the last beat accepted with count=0.
REQ-021 Undefined-length INCR SHALL hold BURST while HTRANS is SEQ or BUSY and SHALL exit on IDLE or NONSEQ.
REQ-022 BUSY beats SHALL neither decrement the counter nor release the lock.
REQ-023 Early burst termination (HTRANS IDLE/NONSEQ while count>0) SHALL clear the counter and return to GRANT arbitration in the same ready cycle.
REQ-024 With HREADY_Outputstage=0, state, counter and outputs SHALL all hold, whatever the request changes.
REQ-025 Simultaneous requests SHALL be resolved per REQ-031/REQ-032.
REQ-026 A deasserted request of the granted port SHALL be ignored while in BURST.
REQ-027 PORT_NOSEL_ARBITER SHALL equal 1 exactly when PORT_SEL_ARBITER=2'b00.

Reset
REQ-028 On HRESET=1, the block SHALL asynchronously go to: FSM=IDLE, beat counter=0, PORT_SEL_ARBITER=PORT_DEFAULT, PORT_NOSEL_ARBITER=(PORT_DEFAULT==2'b00), round-robin pointer=ICODE.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no residual lock.
REQ-030 The first arbitration SHALL occur on the first ready edge after HRESET is released.

Configuration
REQ-031 With macro AHB_ARB_ROUND_ROBIN_EN defined:
- Arbitration SHALL be round-robin, order ICODE->DCODE->SYS->ICODE.
- The pointer SHALL advance to the port after the one granted.
- The pointer SHALL update only when a new grant is issued.
REQ-032 Without AHB_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority DCODE > ICODE > SYS, and there SHALL be no pointer register.

Structure
REQ-033 Shared package ahb_bm_pkg SHALL hold:
- port-code constants (NONE/ICODE/DCODE/SYS);
- HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
- HBURST encodings;
- the arbiter FSM state enum.
REQ-034 The beat counter SHALL be the single sub-module ahblite_busmatrix_burst_cnt: load/decrement/clear inputs, a zero flag output, 4-bit count.

Verification
REQ-035 Reset then REQ_SYS=1, HREADY=1 -> PORT_SEL=11, NOSEL=0 after one edge; HRESET pulse -> 00/1 immediately.
REQ-036 ICODE granted issuing INCR4 (NONSEQ + 3 SEQ); REQ_DCODE raised at beat 1 -> PORT_SEL stays 01 until the 4th beat is accepted, then 10.
REQ-037 HREADY held 0 for 5 cycles mid-INCR8 with request changes -> outputs and counter frozen; burst completes after 8 accepted beats.
REQ-038 INCR burst with 2 BUSY beats then IDLE -> lock held through BUSY, released on IDLE.
REQ-039 All three requests held continuously, SINGLE transfers -> with AHB_ARB_ROUND_ROBIN_EN the grants cycle 01,10,11,01; without it the grant stays 10.
REQ-040 WRAP8 terminated by NONSEQ after beat 3 -> counter cleared, re-arbitration on that edge.

Source files
------------

// File: rtl/ahb_bm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bm_pkg
// Brief    : Shared AHB-Lite bus-matrix codes: port grants, HTRANS, HBURST,
//            arbiter FSM states and small decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_bm_pkg;

    localparam logic [1:0] c_PORT_NONE     = 2'b00;
    localparam logic [1:0] c_PORT_ICODE    = 2'b01;
    localparam logic [1:0] c_PORT_DCODE    = 2'b10;
    localparam logic [1:0] c_PORT_SYS      = 2'b11;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] c_HBURST_SINGLE = 3'b000;
    localparam logic [2:0] c_HBURST_INCR   = 3'b001;
    localparam logic [2:0] c_HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] c_HBURST_INCR4  = 3'b011;
    localparam logic [2:0] c_HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] c_HBURST_INCR8  = 3'b101;
    localparam logic [2:0] c_HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] c_HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BURST = 2'd2
    } arb_state_t;

    // SEQ beats still to come after the NONSEQ of a fixed-length burst
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            c_HBURST_WRAP4,  c_HBURST_INCR4:  burst_beats = 4'd3;
            c_HBURST_WRAP8,  c_HBURST_INCR8:  burst_beats = 4'd7;
            c_HBURST_WRAP16, c_HBURST_INCR16: burst_beats = 4'd15;
            default:                          burst_beats = 4'd0;
        endcase
    endfunction

    function automatic logic [1:0] next_port(input logic [1:0] port);
        case (port)
            c_PORT_ICODE: next_port = c_PORT_DCODE;
            c_PORT_DCODE: next_port = c_PORT_SYS;
            default:      next_port = c_PORT_ICODE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahblite_busmatrix_burst_cnt.sv
`default_nettype none
// ============================================================================
// Module   : ahblite_busmatrix_burst_cnt
// Brief    : 4-bit remaining-beat counter with clear > load > decrement.
// Revision : 1.0 - initial release
// ============================================================================
module ahblite_busmatrix_burst_cnt (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    input  logic       i_clr,
    output logic [3:0] o_count,
    output logic       o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_count <= 4'd0;
        end else if (i_clr) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == 4'd0);

endmodule
`default_nettype wire

// File: rtl/ahblite_busmatrix_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : ahblite_busmatrix_arbiter_rr
// Brief    : Output-stage arbiter for ICODE/DCODE/SYS with burst locking.
//            AHB_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module ahblite_busmatrix_arbiter_rr
    import ahb_bm_pkg::*;
#(
    parameter logic [1:0] PORT_DEFAULT = 2'b00
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       REQ_ICODE,
    input  logic       REQ_DCODE,
    input  logic       REQ_SYS,
    input  logic       HREADY_Outputstage,
    input  logic       HSEL_Outputstage,
    input  logic [1:0] HTRANS_Outputstage,
    input  logic [2:0] HBURST_Outputstage,
    output logic [1:0] PORT_SEL_ARBITER,
    output logic       PORT_NOSEL_ARBITER
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [1:0] r_sel;
    logic [1:0] w_sel_nxt;
    logic       r_nosel;
    logic [1:0] w_arb_sel;
    logic       w_any;
    logic       w_rearb;
    logic       w_cnt_load;
    logic       w_cnt_dec;
    logic       w_cnt_clr;
    logic [3:0] w_cnt;
    logic       w_cnt_zero;

    assign w_any = REQ_ICODE | REQ_DCODE | REQ_SYS;

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic [1:0] r_ptr;

    // r_ptr names the port searched first
    always_comb begin
        w_arb_sel = c_PORT_NONE;
        case (r_ptr)
            c_PORT_DCODE: w_arb_sel = REQ_DCODE ? c_PORT_DCODE :
                                      REQ_SYS   ? c_PORT_SYS   :
                                      REQ_ICODE ? c_PORT_ICODE : c_PORT_NONE;
            c_PORT_SYS:   w_arb_sel = REQ_SYS   ? c_PORT_SYS   :
                                      REQ_ICODE ? c_PORT_ICODE :
                                      REQ_DCODE ? c_PORT_DCODE : c_PORT_NONE;
            default:      w_arb_sel = REQ_ICODE ? c_PORT_ICODE :
                                      REQ_DCODE ? c_PORT_DCODE :
                                      REQ_SYS   ? c_PORT_SYS   : c_PORT_NONE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_ptr <= c_PORT_ICODE;
        end else if (w_rearb && w_any) begin
            r_ptr <= next_port(w_arb_sel);
        end
    end
`else
    assign w_arb_sel = REQ_DCODE ? c_PORT_DCODE :
                       REQ_ICODE ? c_PORT_ICODE :
                       REQ_SYS   ? c_PORT_SYS   : c_PORT_NONE;
`endif

    // In BURST a zero count means undefined-length INCR: fixed bursts leave
    // BURST on the same edge their count reaches zero.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_rearb     = 1'b0;
        if (HREADY_Outputstage) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        w_rearb = 1'b1;
                    end else begin
                        w_sel_nxt = c_PORT_NONE;
                    end
                end
                ST_GRANT: begin
                    if (HSEL_Outputstage &&
                        (HTRANS_Outputstage == c_HTRANS_NONSEQ) &&
                        (HBURST_Outputstage != c_HBURST_SINGLE)) begin
                        w_state_nxt = ST_BURST;
                        w_cnt_load  = 1'b1;
                    end else begin
                        w_rearb = 1'b1;
                    end
                end
                ST_BURST: begin
                    case (HTRANS_Outputstage)
                        c_HTRANS_SEQ: begin
                            if (!w_cnt_zero) begin
                                w_cnt_dec = 1'b1;
                                w_rearb   = (w_cnt == 4'd1);
                            end
                        end
                        c_HTRANS_BUSY: begin
                        end
                        default: begin
                            w_cnt_clr = 1'b1;
                            w_rearb   = 1'b1;
                        end
                    endcase
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = c_PORT_NONE;
                end
            endcase
            if (w_rearb) begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_arb_sel;
                end else if (HTRANS_Outputstage == c_HTRANS_IDLE) begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = c_PORT_NONE;
                end else begin
                    w_state_nxt = ST_GRANT;
                end
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
            r_sel   <= PORT_DEFAULT;
            r_nosel <= (PORT_DEFAULT == c_PORT_NONE);
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_nosel <= (w_sel_nxt == c_PORT_NONE);
        end
    end

    ahblite_busmatrix_burst_cnt u_burst_cnt (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .i_load     (w_cnt_load),
        .i_load_val (burst_beats(HBURST_Outputstage)),
        .i_dec      (w_cnt_dec),
        .i_clr      (w_cnt_clr),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    assign PORT_SEL_ARBITER   = r_sel;
    assign PORT_NOSEL_ARBITER = r_nosel;

endmodule
`default_nettype wire

// File: tb/tb_ahblite_busmatrix_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahblite_busmatrix_arbiter_rr
// Brief    : Directed bench with a cycle-level grant model and literal pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahblite_busmatrix_arbiter_rr;

    localparam logic [1:0] c_DEF = 2'b00;
    localparam logic [2:0] c_RI = 3'b001, c_RD = 3'b010, c_RS = 3'b100;
    localparam logic [1:0] c_TI = 2'd0, c_TB = 2'd1, c_TN = 2'd2, c_TS = 2'd3;
    localparam logic [2:0] c_BSINGLE = 3'd0, c_BINCR = 3'd1, c_BINCR4 = 3'd3;
    localparam logic [2:0] c_BWRAP8 = 3'd4, c_BINCR8 = 3'd5;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b0;
    logic       REQ_ICODE = 1'b0, REQ_DCODE = 1'b0, REQ_SYS = 1'b0;
    logic       HREADY = 1'b1, HSEL = 1'b0;
    logic [1:0] HTRANS = 2'd0;
    logic [2:0] HBURST = 3'd0;
    logic [1:0] PORT_SEL_ARBITER;
    logic       PORT_NOSEL_ARBITER;

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    always #5 HCLK = ~HCLK;

    ahblite_busmatrix_arbiter_rr #(.PORT_DEFAULT(c_DEF)) dut (
        .HCLK               (HCLK),
        .HRESET             (HRESET),
        .REQ_ICODE          (REQ_ICODE),
        .REQ_DCODE          (REQ_DCODE),
        .REQ_SYS            (REQ_SYS),
        .HREADY_Outputstage (HREADY),
        .HSEL_Outputstage   (HSEL),
        .HTRANS_Outputstage (HTRANS),
        .HBURST_Outputstage (HBURST),
        .PORT_SEL_ARBITER   (PORT_SEL_ARBITER),
        .PORT_NOSEL_ARBITER (PORT_NOSEL_ARBITER)
    );

    // Model: who holds the grant, whether it is locked, SEQ beats still owed
    typedef struct {
        logic [1:0] sel;
        bit         locked;
        bit         incr;
        int         left;
        int         ptr;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t s);
        model_t     n;
        logic [2:0] req;
        bit         rearb;
        bit         found;
        int         idx;
        n     = s;
        req   = {REQ_SYS, REQ_DCODE, REQ_ICODE};
        rearb = 1'b0;
        found = 1'b0;
        if (!HREADY) return s;
        if (!s.locked) begin
            if (s.sel != 2'd0 && HSEL && HTRANS == c_TN && HBURST != c_BSINGLE) begin
                n.locked = 1'b1;
                n.incr   = (HBURST == c_BINCR);
                n.left   = n.incr ? 0 : (1 << ((HBURST >> 1) + 1)) - 1;
            end else begin
                rearb = 1'b1;
            end
        end else if (s.incr) begin
            if (HTRANS == c_TI || HTRANS == c_TN) begin
                n.locked = 1'b0;
                rearb    = 1'b1;
            end
        end else if (HTRANS == c_TS) begin
            n.left = s.left - 1;
            if (n.left == 0) begin
                n.locked = 1'b0;
                rearb    = 1'b1;
            end
        end else if (HTRANS == c_TI || HTRANS == c_TN) begin
            n.left   = 0;
            n.locked = 1'b0;
            rearb    = 1'b1;
        end
        if (rearb) begin
            if (req != 3'd0) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
                for (int k = 0; k < 3; k++) begin
                    idx = (s.ptr + k) % 3;
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        n.sel = 2'(idx + 1);
                        n.ptr = (idx + 1) % 3;
                    end
                end
`else
                if (req[1])      n.sel = 2'd2;
                else if (req[0]) n.sel = 2'd1;
                else             n.sel = 2'd3;
`endif
            end else if (HTRANS == c_TI || s.sel == 2'd0) begin
                n.sel = 2'd0;
            end
        end
        return n;
    endfunction

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) m <= '{sel: c_DEF, locked: 1'b0, incr: 1'b0, left: 0, ptr: 0};
        else        m <= model_next(m);
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge HCLK) begin
        if (chk_en) begin
            chk("model_sel",   {2'b00, PORT_SEL_ARBITER}, {2'b00, m.sel});
            chk("model_nosel", {3'b000, PORT_NOSEL_ARBITER}, {3'b000, m.sel == 2'd0});
            chk("model_count", dut.u_burst_cnt.o_count, 4'(m.left));
        end
    end

    task automatic step(input logic [2:0] req, input logic [1:0] tr,
                        input logic [2:0] hb, input logic rdy);
        {REQ_SYS, REQ_DCODE, REQ_ICODE} = req;
        HTRANS = tr;
        HBURST = hb;
        HREADY = rdy;
        HSEL   = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic lit(input string name, input logic [1:0] sel, input logic [3:0] cnt);
        chk({name, "_sel"},   {2'b00, PORT_SEL_ARBITER}, {2'b00, sel});
        chk({name, "_nosel"}, {3'b000, PORT_NOSEL_ARBITER}, {3'b000, sel == 2'd0});
        chk({name, "_cnt"},   dut.u_burst_cnt.o_count, cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_seq [0:3];
`ifdef AHB_ARB_ROUND_ROBIN_EN
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b11; exp_seq[3] = 2'b01;
`else
        exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b10; exp_seq[3] = 2'b10;
`endif
        #1 HRESET = 1'b1;
        chk_en = 1'b1;
        @(negedge HCLK);
        lit("reset", 2'b00, 4'd0);
        @(negedge HCLK);
        HRESET = 1'b0;

        // SYS grant after one edge, then an asynchronous reset pulse
        step(c_RS, c_TI, c_BSINGLE, 1'b1);
        lit("sys_grant", 2'b11, 4'd0);
        #1 HRESET = 1'b1;
        #1 lit("async_reset", 2'b00, 4'd0);
        #2 HRESET = 1'b0;

        // INCR4 from ICODE, DCODE requesting from beat 1
        step(c_RI, c_TI, c_BSINGLE, 1'b1);
        lit("icode_grant", 2'b01, 4'd0);
        step(c_RI, c_TN, c_BINCR4, 1'b1);
        lit("incr4_load", 2'b01, 4'd3);
        step(c_RI | c_RD, c_TS, c_BINCR4, 1'b1);
        step(c_RI | c_RD, c_TS, c_BINCR4, 1'b1);
        lit("incr4_locked", 2'b01, 4'd1);
        step(c_RI | c_RD, c_TS, c_BINCR4, 1'b1);
        lit("incr4_release", 2'b10, 4'd0);
        step(3'd0, c_TI, c_BSINGLE, 1'b1);
        lit("idle_after_incr4", 2'b00, 4'd0);

        // INCR8 from DCODE with a 5-cycle stall and churning requests
        step(c_RD, c_TI, c_BSINGLE, 1'b1);
        step(c_RD, c_TN, c_BINCR8, 1'b1);
        lit("incr8_load", 2'b10, 4'd7);
        step(c_RD, c_TS, c_BINCR8, 1'b1);
        step(c_RD, c_TS, c_BINCR8, 1'b1);
        for (int k = 0; k < 5; k++)
            step((k % 2 == 1) ? (c_RI | c_RS) : c_RS, (k % 2 == 1) ? c_TS : c_TI, c_BINCR8, 1'b0);
        lit("stall_hold", 2'b10, 4'd5);
        for (int k = 0; k < 4; k++) step(c_RI, c_TS, c_BINCR8, 1'b1);
        lit("incr8_beat7", 2'b10, 4'd1);
        step(c_RI, c_TS, c_BINCR8, 1'b1);
        lit("incr8_release", 2'b01, 4'd0);
        step(3'd0, c_TI, c_BSINGLE, 1'b1);

        // Undefined-length INCR with BUSY beats
        step(c_RS, c_TI, c_BSINGLE, 1'b1);
        step(c_RS, c_TN, c_BINCR, 1'b1);
        step(c_RI, c_TS, c_BINCR, 1'b1);
        step(c_RI, c_TB, c_BINCR, 1'b1);
        step(c_RI, c_TB, c_BINCR, 1'b1);
        lit("busy_hold", 2'b11, 4'd0);
        step(c_RI, c_TI, c_BINCR, 1'b1);
        lit("incr_release", 2'b01, 4'd0);
        step(3'd0, c_TI, c_BSINGLE, 1'b1);

        // WRAP8 cut short by a NONSEQ after its third beat
        step(c_RI, c_TI, c_BSINGLE, 1'b1);
        step(c_RI, c_TN, c_BWRAP8, 1'b1);
        step(c_RI, c_TS, c_BWRAP8, 1'b1);
        step(c_RI, c_TS, c_BWRAP8, 1'b1);
        lit("wrap8_mid", 2'b01, 4'd5);
        step(c_RI | c_RD, c_TN, c_BSINGLE, 1'b1);
        lit("wrap8_early_end", 2'b10, 4'd0);
        step(3'd0, c_TI, c_BSINGLE, 1'b1);

        // Fresh reset, then all three requesting with SINGLE transfers
        #1 HRESET = 1'b1;
        #2 HRESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(c_RI | c_RD | c_RS, c_TN, c_BSINGLE, 1'b1);
            lit($sformatf("all_req_%0d", k), exp_seq[k], 4'd0);
        end
        step(3'd0, c_TN, c_BSINGLE, 1'b1);
        lit("noreq_hold", exp_seq[3], 4'd0);
        step(3'd0, c_TI, c_BSINGLE, 1'b1);
        lit("noreq_idle", 2'b00, 4'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
